// File: rtl/vx_commit_arbiter_if.sv
// Commit/writeback bus between the execution units, the commit arbiter and the GPR file.
// master = execution units + GPR side, slave = arbiter side.
interface vx_commit_arbiter_if #(
    parameter int unsigned NUM_REQS    = 5,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 5
);
    logic [NUM_REQS-1:0]                commit_valid;
    logic [NUM_REQS-1:0]                commit_ready;
    logic [NUM_REQS*NW_BITS-1:0]        commit_wid;
    logic [NUM_REQS*NUM_THREADS-1:0]    commit_tmask;
    logic [NUM_REQS*32-1:0]             commit_PC;
    logic [NUM_REQS*NR_BITS-1:0]        commit_rd;
    logic [NUM_REQS-1:0]                commit_wb;
    logic [NUM_REQS-1:0]                commit_eop;
    logic [NUM_REQS*NUM_THREADS*32-1:0] commit_data;

    logic                               wb_valid;
    logic                               wb_ready;
    logic [NW_BITS-1:0]                 wb_wid;
    logic [NUM_THREADS-1:0]             wb_tmask;
    logic [31:0]                        wb_PC;
    logic [NR_BITS-1:0]                 wb_rd;
    logic [NUM_THREADS*32-1:0]          wb_data;
    logic                               wb_eop;

    logic [31:0]                        instr_retired;

    modport master (
        output commit_valid, commit_wid, commit_tmask, commit_PC, commit_rd,
               commit_wb, commit_eop, commit_data, wb_ready,
        input  commit_ready, wb_valid, wb_wid, wb_tmask, wb_PC, wb_rd,
               wb_data, wb_eop, instr_retired
    );

    modport slave (
        input  commit_valid, commit_wid, commit_tmask, commit_PC, commit_rd,
               commit_wb, commit_eop, commit_data, wb_ready,
        output commit_ready, wb_valid, wb_wid, wb_tmask, wb_PC, wb_rd,
               wb_data, wb_eop, instr_retired
    );
endinterface

// File: rtl/vx_commit_arbiter.sv
// Round-robin commit arbiter: merges execution-unit commits into one registered
// writeback stream, locking onto multi-beat packets and counting retired instructions.
module vx_commit_arbiter #(
    parameter int unsigned NUM_REQS    = 5,
    parameter int unsigned NUM_THREADS = 4,
    parameter int unsigned NW_BITS     = 2,
    parameter int unsigned NR_BITS     = 5
) (
    input logic               clk,
    input logic               reset,
    vx_commit_arbiter_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(NUM_REQS);
    localparam int unsigned DATA_W = NUM_THREADS * 32;

    logic             lock_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] prio_q;

    logic [NUM_REQS-1:0] eligible;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic                stage_free;
    logic                accept;
    logic                load;
    logic                win_eop;

    // While a packet is open only its owner may compete.
    assign eligible   = lock_q ? (bus.commit_valid & (NUM_REQS'(1) << owner_q))
                               : bus.commit_valid;
    assign stage_free = !bus.wb_valid || bus.wb_ready;

    // First eligible channel at or after the priority pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            cand = IDX_W'((32'(prio_q) + i) % NUM_REQS);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Non-writing commits retire even when the output stage is stalled.
    assign accept  = win_found && (!bus.commit_wb[win_idx] || stage_free);
    assign load    = accept && bus.commit_wb[win_idx];
    assign win_eop = bus.commit_eop[win_idx];

    always_comb begin
        bus.commit_ready = '0;
        if (accept) begin
            bus.commit_ready = NUM_REQS'(1) << win_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q            <= 1'b0;
            owner_q           <= '0;
            prio_q            <= '0;
            bus.wb_valid      <= 1'b0;
            bus.wb_wid        <= '0;
            bus.wb_tmask      <= '0;
            bus.wb_PC         <= '0;
            bus.wb_rd         <= '0;
            bus.wb_data       <= '0;
            bus.wb_eop        <= 1'b0;
            bus.instr_retired <= '0;
        end else begin
            if (load) begin
                bus.wb_valid <= 1'b1;
                bus.wb_wid   <= bus.commit_wid[32'(win_idx) * NW_BITS +: NW_BITS];
                bus.wb_tmask <= bus.commit_tmask[32'(win_idx) * NUM_THREADS +: NUM_THREADS];
                bus.wb_PC    <= bus.commit_PC[32'(win_idx) * 32 +: 32];
                bus.wb_rd    <= bus.commit_rd[32'(win_idx) * NR_BITS +: NR_BITS];
                bus.wb_data  <= bus.commit_data[32'(win_idx) * DATA_W +: DATA_W];
                bus.wb_eop   <= win_eop;
            end else if (bus.wb_ready) begin
                bus.wb_valid <= 1'b0;
            end

            if (accept) begin
                lock_q  <= !win_eop;
                owner_q <= win_idx;
                if (win_eop) begin
                    prio_q            <= (win_idx == IDX_W'(NUM_REQS - 1)) ? '0
                                                                          : win_idx + IDX_W'(1);
                    bus.instr_retired <= bus.instr_retired + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Scoreboard bench for vx_commit_arbiter: expected writeback beats are queued as
// stimulus is granted and compared when they leave the output register.
module tb_vx_commit_arbiter;
    localparam int NR = 5;
    localparam int NT = 4;

    typedef struct {
        logic [1:0]       wid;
        logic [NT-1:0]    tmask;
        logic [31:0]      pc;
        logic [4:0]       rd;
        logic [NT*32-1:0] data;
        logic             eop;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_commit_arbiter_if bus ();
    vx_commit_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    beat_t exp_q[$];
    beat_t cur[NR];
    beat_t mon_e;
    int    checks = 0;
    int    errors = 0;

    function automatic beat_t mb(int ch, int seq, logic eop);
        beat_t b;
        b.wid   = 2'(ch + seq);
        b.tmask = 4'(ch * 3 + seq + 1);
        b.pc    = 32'h8000_0000 + 32'(ch * 256 + seq * 4);
        b.rd    = 5'(ch * 5 + seq + 1);
        for (int l = 0; l < NT; l++)
            b.data[l*32 +: 32] = 32'hA000_0000 ^ 32'(ch << 16) ^ 32'(seq << 4) ^ 32'(l);
        b.eop = eop;
        return b;
    endfunction

    task automatic drive(int ch, beat_t b, logic wb);
        cur[ch] = b;
        bus.commit_valid[ch]        = 1'b1;
        bus.commit_wid[ch*2 +: 2]   = b.wid;
        bus.commit_tmask[ch*NT +: NT] = b.tmask;
        bus.commit_PC[ch*32 +: 32]  = b.pc;
        bus.commit_rd[ch*5 +: 5]    = b.rd;
        bus.commit_wb[ch]           = wb;
        bus.commit_eop[ch]          = b.eop;
        bus.commit_data[ch*NT*32 +: NT*32] = b.data;
    endtask

    task automatic idle(int ch);
        bus.commit_valid[ch] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.commit_valid = '0;
        bus.wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Output monitor: a beat transfers on the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.wb_valid === 1'b1 && bus.wb_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d pc=%h, required no beat", bus.wb_rd, bus.wb_PC);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.wb_wid !== mon_e.wid || bus.wb_tmask !== mon_e.tmask ||
                    bus.wb_PC !== mon_e.pc || bus.wb_rd !== mon_e.rd ||
                    bus.wb_data !== mon_e.data || bus.wb_eop !== mon_e.eop) begin
                    errors++;
                    $display("FAIL wb_beat: got wid=%0d tm=%h pc=%h rd=%0d eop=%b data=%h, required wid=%0d tm=%h pc=%h rd=%0d eop=%b data=%h",
                             bus.wb_wid, bus.wb_tmask, bus.wb_PC, bus.wb_rd, bus.wb_eop, bus.wb_data,
                             mon_e.wid, mon_e.tmask, mon_e.pc, mon_e.rd, mon_e.eop, mon_e.data);
                end
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        bus.commit_valid = '0;
        bus.wb_ready = 1'b1;
        tick();
        checks += 5;
        if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b, required 0", bus.wb_valid); end
        if (bus.instr_retired !== 32'd0) begin errors++; $display("FAIL reset_retired: got %h, required 0", bus.instr_retired); end
        if (bus.wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h, required 0", bus.wb_data); end
        if (bus.wb_PC !== 32'd0) begin errors++; $display("FAIL reset_wb_pc: got %h, required 0", bus.wb_PC); end
        if (bus.commit_ready !== 5'b0) begin errors++; $display("FAIL reset_ready: got %b, required 00000", bus.commit_ready); end
        reset = 1'b1;
    endtask

    task automatic test_single();
        beat_t b;
        do_reset();
        b.wid = 2'd1; b.tmask = 4'hF; b.pc = 32'h8000_0000; b.rd = 5'd5;
        b.data = '0; b.data[31:0] = 32'h1234; b.eop = 1'b1;
        drive(0, b, 1'b1);
        #1;
        checks++;
        if (bus.commit_ready !== 5'b00001) begin errors++; $display("FAIL single_ready: got %b, required 00001", bus.commit_ready); end
        exp_q.push_back(b);
        tick();
        idle(0);
        #1;
        checks += 2;
        if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b, required 1", bus.wb_valid); end
        if (bus.instr_retired !== 32'd1) begin errors++; $display("FAIL single_retired: got %0d, required 1", bus.instr_retired); end
        tick();
        checks++;
        if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_wb_clear: got %b, required 0", bus.wb_valid); end
        wait_drain("single");
    endtask

    task automatic test_round_robin();
        int seq[NR];
        int g;
        do_reset();
        for (int c = 0; c < NR; c++) begin
            seq[c] = 0;
            drive(c, mb(c, 0, 1'b1), 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            g = i % NR;
            if (i == 5) begin
                checks++;
                if (bus.instr_retired !== 32'd5) begin errors++; $display("FAIL rr_retired: got %0d, required 5", bus.instr_retired); end
            end
            #1;
            checks++;
            if (bus.commit_ready !== 5'(1 << g)) begin errors++; $display("FAIL rr_grant%0d: got %b, required %b", i, bus.commit_ready, 5'(1 << g)); end
            exp_q.push_back(cur[g]);
            tick();
            seq[g]++;
            drive(g, mb(g, seq[g], 1'b1), 1'b1);
        end
        bus.commit_valid = '0;
        wait_drain("rr");
    endtask

    task automatic test_lock();
        int seq[NR];
        int exp_g[7] = '{0, 1, 1, -1, 1, 4, 0};
        int g;
        logic [4:0] m;
        do_reset();
        seq = '{default: 0};
        drive(0, mb(0, 0, 1'b1), 1'b1);
        drive(4, mb(4, 0, 1'b1), 1'b1);
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: drive(1, mb(1, 0, 1'b0), 1'b1);
                2: drive(1, mb(1, 1, 1'b0), 1'b1);
                3: idle(1);
                4: drive(1, mb(1, 2, 1'b1), 1'b1);
                5: idle(1);
                default: ;
            endcase
            g = exp_g[i];
            m = (g < 0) ? 5'b0 : 5'(1 << g);
            #1;
            checks++;
            if (bus.commit_ready !== m) begin errors++; $display("FAIL lock_grant%0d: got %b, required %b", i, bus.commit_ready, m); end
            if (g >= 0) exp_q.push_back(cur[g]);
            tick();
            if (g == 0 || g == 4) begin
                seq[g]++;
                drive(g, mb(g, seq[g], 1'b1), 1'b1);
            end
        end
        bus.commit_valid = '0;
        wait_drain("lock");
    endtask

    task automatic test_stall_nowb();
        beat_t held;
        do_reset();
        bus.wb_ready = 1'b0;
        held = mb(0, 0, 1'b1);
        drive(0, held, 1'b1);
        #1;
        checks++;
        if (bus.commit_ready !== 5'b00001) begin errors++; $display("FAIL stall_load_ready: got %b, required 00001", bus.commit_ready); end
        exp_q.push_back(held);
        tick();
        drive(0, mb(0, 1, 1'b1), 1'b1);
        drive(2, mb(2, 0, 1'b1), 1'b0);
        #1;
        checks++;
        if (bus.commit_ready !== 5'b00100) begin errors++; $display("FAIL stall_csr_ready: got %b, required 00100", bus.commit_ready); end
        tick();
        idle(2);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks += 5;
            if (bus.commit_ready !== 5'b0) begin errors++; $display("FAIL stall_alu_ready%0d: got %b, required 00000", k, bus.commit_ready); end
            if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL stall_wb_valid%0d: got %b, required 1", k, bus.wb_valid); end
            if (bus.wb_rd !== held.rd) begin errors++; $display("FAIL stall_hold_rd%0d: got %0d, required %0d", k, bus.wb_rd, held.rd); end
            if (bus.wb_data !== held.data) begin errors++; $display("FAIL stall_hold_data%0d: got %h, required %h", k, bus.wb_data, held.data); end
            if (bus.instr_retired !== 32'd2) begin errors++; $display("FAIL stall_retired%0d: got %0d, required 2", k, bus.instr_retired); end
            tick();
        end
        bus.wb_ready = 1'b1;
        #1;
        checks++;
        if (bus.commit_ready !== 5'b00001) begin errors++; $display("FAIL stall_release_ready: got %b, required 00001", bus.commit_ready); end
        exp_q.push_back(cur[0]);
        tick();
        idle(0);
        wait_drain("stall");
    endtask

    task automatic test_wrap();
        do_reset();
        force bus.instr_retired = 32'hFFFF_FFFF;
        #1;
        release bus.instr_retired;
        #1;
        checks++;
        if (bus.instr_retired !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h, required ffffffff", bus.instr_retired); end
        drive(3, mb(3, 0, 1'b1), 1'b0);
        #1;
        checks++;
        if (bus.commit_ready !== 5'b01000) begin errors++; $display("FAIL wrap_ready: got %b, required 01000", bus.commit_ready); end
        tick();
        idle(3);
        #1;
        checks += 2;
        if (bus.instr_retired !== 32'd0) begin errors++; $display("FAIL wrap_retired: got %h, required 0", bus.instr_retired); end
        if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL wrap_wb_valid: got %b, required 0", bus.wb_valid); end
        wait_drain("wrap");
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, mb(1, 0, 1'b0), 1'b1);
        #1;
        checks++;
        if (bus.commit_ready !== 5'b00010) begin errors++; $display("FAIL mid_first_ready: got %b, required 00010", bus.commit_ready); end
        exp_q.push_back(cur[1]);
        tick();
        drive(1, mb(1, 1, 1'b0), 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks += 4;
        if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mid_wb_valid: got %b, required 0", bus.wb_valid); end
        if (bus.wb_data !== '0) begin errors++; $display("FAIL mid_wb_data: got %h, required 0", bus.wb_data); end
        if (bus.wb_PC !== 32'd0) begin errors++; $display("FAIL mid_wb_pc: got %h, required 0", bus.wb_PC); end
        if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL mid_wb_rd: got %0d, required 0", bus.wb_rd); end
        drive(0, mb(0, 0, 1'b1), 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.commit_ready !== 5'b00001) begin errors++; $display("FAIL mid_after_ready: got %b, required 00001", bus.commit_ready); end
        exp_q.push_back(cur[0]);
        tick();
        bus.commit_valid = '0;
        wait_drain("mid");
    endtask

    initial begin
        bus.commit_valid = '0;
        bus.commit_wid   = '0;
        bus.commit_tmask = '0;
        bus.commit_PC    = '0;
        bus.commit_rd    = '0;
        bus.commit_wb    = '0;
        bus.commit_eop   = '0;
        bus.commit_data  = '0;
        bus.wb_ready     = 1'b1;
        reset            = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_stall_nowb();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule

// File: doc/vx_commit_arbiter.md
# VX_commit_arbiter

Collects completed results from the five execution units (ALU, LSU, CSR, FPU, GPU) that receive requests from the issue-stage dispatch, and merges them into one writeback stream to the GPR file. It uses round-robin arbitration with multi-beat packet locking and a registered output stage. Commits that do not write a register are retired without using a writeback slot. It also keeps a retired-instruction counter for the CSR unit.

## Interface
- NUM_REQS, 5: input channels; index 0=ALU, 1=LSU, 2=CSR, 3=FPU, 4=GPU.
- NUM_THREADS, 4: lanes per commit.
- NW_BITS, 2: warp id width.
- NR_BITS, 5: register index width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- commit_valid  in  NUM_REQS  per-channel commit valid.
- commit_ready  out  NUM_REQS  per-channel accept, combinational.
- commit_wid  in  NUM_REQS*NW_BITS  warp id.
- commit_tmask  in  NUM_REQS*NUM_THREADS  thread mask.
- commit_PC  in  NUM_REQS*32  instruction PC.
- commit_rd  in  NUM_REQS*NR_BITS  destination register.
- commit_wb  in  NUM_REQS  1 = writes the register file.
- commit_eop  in  NUM_REQS  last beat of this instruction.
- commit_data  in  NUM_REQS*NUM_THREADS*32  per-lane result.
- wb_valid  out  1  writeback valid, registered.
- wb_ready  in  1  GPR accepts the writeback.
- wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop  out  as above  registered copy of the winning beat.
- instr_retired  out  32  count of accepted eop beats, registered.

## Operation
- Eligible set:
  - Unlocked: all channels with commit_valid=1.
  - Locked: only the lock owner.
- Winner: the first eligible channel, searching upward from priority pointer prio, with wrap-around modulo NUM_REQS.
- stage_free = !wb_valid || wb_ready.
- The winner is accepted (commit_ready[winner]=1) when (winner.wb=0) OR stage_free. All other commit_ready bits are 0. There is no fallback to another channel in the same cycle.
- Accepted beat with wb=1: it is loaded into the output register (wb_valid←1), and all fields are copied.
- Accepted beat with wb=0: it is dropped and the output register is unchanged. If stage_free and nothing loads, wb_valid←0.
- Output register with no load: if wb_ready=1, wb_valid←0; otherwise it holds all fields.
- Lock:
  - An accepted beat with eop=0 sets lock=1, owner=winner.
  - An accepted beat with eop=1 clears lock.
- Priority: on an accepted eop=1 beat, prio←(winner+1) mod NUM_REQS. Otherwise prio is unchanged.
- instr_retired increments by 1 on every accepted eop=1 beat, regardless of wb. It wraps from 0xFFFFFFFF to 0.
- Reset (asynchronous assert, any time, including mid-packet):
  - wb_valid=0, lock=0, prio=0, instr_retired=0.
  - Data fields go to 0.
  - An in-flight packet is abandoned.

## Timing
- Latency: a beat accepted in cycle N appears on wb_* in cycle N+1.
- Throughput: 1 beat/cycle while wb_ready=1.
- commit_ready depends combinationally on commit_valid, commit_wb, wb_valid and wb_ready. It never depends on the data fields.
- wb_* fields are stable while wb_valid=1 and wb_ready=0.
- A wb=0 beat can retire in the same cycle the output is stalled.
- Deassertion of reset takes effect at the next clk edge. The first accept can occur in the cycle after reset deasserts.

## Test plan
- Reset, then ALU sends one beat (wid=1, rd=5, PC=0x80000000, data lane0=0x1234, wb=1, eop=1) with wb_ready=1 -> commit_ready[0]=1 in cycle 0; wb_valid=1 with identical fields in cycle 1; instr_retired=1; wb_valid=0 in cycle 2.
- All five channels hold valid eop beats continuously with wb_ready=1 -> grant order 0,1,2,3,4,0,…; instr_retired=5 after 5 accepts.
- LSU sends a 3-beat packet (eop on beat 3) while ALU and GPU stay valid -> three consecutive LSU beats appear on the output with no interleaving; the next grant goes to CSR (if valid), else FPU, else GPU.
- wb_ready=0 with output full; CSR commits with wb=0, eop=1 -> CSR is accepted; the output holds unchanged; instr_retired increments. A concurrent ALU wb=1 beat gets commit_ready=0 until wb_ready=1.
- Preload instr_retired=0xFFFFFFFF via 2^32−1 accepts (or force), then accept one eop beat -> instr_retired=0.
- Assert reset mid-packet (after LSU beat 1 of 3) -> all outputs go to 0 immediately. After release, prio=0 and no lock: ALU is granted first.
